// File: rtl/sfx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sfx_pkg : effect codes, note dividers and sequence tables          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package sfx_pkg;

    typedef enum logic [1:0] {
        SFX_NONE  = 2'd0,
        SFX_JUMP  = 2'd1,
        SFX_SCORE = 2'd2,
        SFX_DIE   = 2'd3
    } sfx_code_t;

    // Divider 1 is rendered as silence by note_gen.
    localparam logic [21:0] DIV_SIL = 22'd1;
    localparam logic [21:0] DIV_C4  = 22'd95418;
    localparam logic [21:0] DIV_E4  = 22'd75756;
    localparam logic [21:0] DIV_G4  = 22'd63774;

    localparam logic [2:0] LEN_JUMP  = 3'd2;
    localparam logic [2:0] LEN_SCORE = 3'd4;
    localparam logic [2:0] LEN_DIE   = 3'd6;

    function automatic logic [2:0] sfx_len(input sfx_code_t fx);
        logic [2:0] len;
        len = 3'd0;
        case (fx)
            SFX_JUMP:  len = LEN_JUMP;
            SFX_SCORE: len = LEN_SCORE;
            SFX_DIE:   len = LEN_DIE;
            default:   len = 3'd0;
        endcase
        return len;
    endfunction

    function automatic logic [21:0] sfx_note(input sfx_code_t fx, input logic [2:0] step);
        logic [21:0] div;
        div = DIV_SIL;
        case (fx)
            SFX_JUMP: begin
                if (step < LEN_JUMP) div = DIV_G4;
            end
            SFX_SCORE: begin
                if (step == 3'd0)          div = DIV_C4;
                else if (step < LEN_SCORE) div = DIV_G4;
            end
            SFX_DIE: begin
                case (step)
                    3'd0, 3'd1: div = DIV_G4;
                    3'd2, 3'd3: div = DIV_E4;
                    3'd4, 3'd5: div = DIV_C4;
                    default:    div = DIV_SIL;
                endcase
            end
            default: div = DIV_SIL;
        endcase
        return div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfx_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sfx_sequencer_if : event requests and note divider outputs         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface sfx_sequencer_if;
    logic        jump;
    logic        score;
    logic        die;
    logic        mute;
    logic [21:0] note_div_left;
    logic [21:0] note_div_right;
    logic        busy;
    logic [1:0]  active_sfx;
    logic        done;

    modport master (
        output jump, score, die, mute,
        input  note_div_left, note_div_right, busy, active_sfx, done
    );

    modport slave (
        input  jump, score, die, mute,
        output note_div_left, note_div_right, busy, active_sfx, done
    );
endinterface
`default_nettype wire

// File: rtl/sfx_sequencer_beat_tick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | beat_tick : modulo-BEAT_DIV counter, tick high in the wrap cycle   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module beat_tick #(
    parameter int BEAT_DIV = 12500000,
    parameter int CNT_W    = 24
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr_i,
    output logic      tick_o
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(BEAT_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Tick is asserted during the last count so the consumer acts on the wrap edge.
    assign tick_o = (cnt_q == c_last);

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sfx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sfx_sequencer : prioritised sound-effect note sequencer            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int BEAT_DIV = 12500000,
    parameter int CNT_W    = 24
) (
    input  wire logic       clk,
    input  wire logic       rst,
    sfx_sequencer_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t      state_q;
    sfx_code_t   active_q;
    logic [2:0]  step_q;
    logic [21:0] note_q;
    logic [21:0] note_d;
    logic        busy_q;
    logic        done_q;

    sfx_code_t   w_req;
    logic        w_tick;
    logic        w_last;
    logic        w_finish;
    logic        w_start;
    logic        w_clr;

    always_comb begin
        w_req = SFX_NONE;
        if (bus.die)        w_req = SFX_DIE;
        else if (bus.score) w_req = SFX_SCORE;
        else if (bus.jump)  w_req = SFX_JUMP;
    end

    assign w_last   = (step_q == (sfx_len(active_q) - 3'd1));
    assign w_finish = (state_q == ST_PLAY) && w_tick && w_last;
    // A completing effect frees the channel, so any request may start on that edge.
    assign w_start  = (w_req != SFX_NONE) && ((w_req > active_q) || w_finish);
    assign w_clr    = (state_q == ST_IDLE) || w_start;

    beat_tick #(
        .BEAT_DIV (BEAT_DIV),
        .CNT_W    (CNT_W)
    ) u_beat_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_clr),
        .tick_o (w_tick)
    );

    always_comb begin
        note_d = sfx_note(active_q, step_q);
        if (w_start) begin
            note_d = sfx_note(w_req, 3'd0);
        end else if (w_finish) begin
            note_d = DIV_SIL;
        end else if ((state_q == ST_PLAY) && w_tick) begin
            note_d = sfx_note(active_q, step_q + 3'd1);
        end
        if (bus.mute) note_d = DIV_SIL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            active_q <= SFX_NONE;
            step_q   <= 3'd0;
            note_q   <= DIV_SIL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= w_finish;
            note_q <= note_d;
            if (w_start) begin
                state_q  <= ST_PLAY;
                active_q <= w_req;
                step_q   <= 3'd0;
                busy_q   <= 1'b1;
            end else if (w_finish) begin
                state_q  <= ST_IDLE;
                active_q <= SFX_NONE;
                step_q   <= 3'd0;
                busy_q   <= 1'b0;
            end else if ((state_q == ST_PLAY) && w_tick) begin
                step_q <= step_q + 3'd1;
            end
        end
    end

    assign bus.note_div_left  = note_q;
    assign bus.note_div_right = note_q;
    assign bus.busy           = busy_q;
    assign bus.active_sfx     = active_q;
    assign bus.done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sfx_sequencer : directed scoreboard bench, BEAT_DIV = 4         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_sfx_sequencer;
    import sfx_pkg::*;

    localparam logic [21:0] SIL = 22'd1;
    localparam logic [21:0] C4  = 22'd95418;
    localparam logic [21:0] E4  = 22'd75756;
    localparam logic [21:0] G4  = 22'd63774;

    typedef struct packed {
        logic [21:0] note;
        logic        busy;
        logic [1:0]  act;
        logic        done;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    int    vectors = 0;
    int    fails   = 0;
    int    cyc     = 0;
    string phase   = "init";
    exp_t  exp_q[$];

    sfx_sequencer_if bus();

    sfx_sequencer #(
        .BEAT_DIV (4),
        .CNT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s %s cycle %0d observed=%0d expected=%0d", phase, tag, cyc, obs, expv);
        end
    endtask

    task automatic push(input int n, input logic [21:0] note, input logic busy,
                        input logic [1:0] act, input logic done);
        exp_t e;
        e.note = note;
        e.busy = busy;
        e.act  = act;
        e.done = done;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.jump  = 1'b0;
            bus.score = 1'b0;
            bus.die   = 1'b0;
            cyc++;
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $error("FAIL %s scoreboard_empty cycle %0d observed=0 expected=1", phase, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("note_div_left",  32'(bus.note_div_left),  32'(e.note));
                chk("note_div_right", 32'(bus.note_div_right), 32'(e.note));
                chk("busy",           32'(bus.busy),           32'(e.busy));
                chk("active_sfx",     32'(bus.active_sfx),     32'(e.act));
                chk("done",           32'(bus.done),           32'(e.done));
            end
        end
    endtask

    initial begin
        bus.jump  = 1'b0;
        bus.score = 1'b0;
        bus.die   = 1'b0;
        bus.mute  = 1'b0;
        rst       = 1'b1;

        phase = "reset";
        push(3, SIL, 1'b0, 2'd0, 1'b0);
        run(3);
        rst = 1'b0;
        push(20, SIL, 1'b0, 2'd0, 1'b0);
        run(20);

        phase = "jump";
        bus.jump = 1'b1;
        push(8, G4, 1'b1, 2'd1, 1'b0);
        push(1, SIL, 1'b0, 2'd0, 1'b1);
        push(2, SIL, 1'b0, 2'd0, 1'b0);
        run(11);

        phase = "score_drop_jump";
        bus.score = 1'b1;
        push(4, C4, 1'b1, 2'd2, 1'b0);
        push(12, G4, 1'b1, 2'd2, 1'b0);
        push(1, SIL, 1'b0, 2'd0, 1'b1);
        push(2, SIL, 1'b0, 2'd0, 1'b0);
        run(5);
        bus.jump = 1'b1;
        run(14);

        phase = "die_preempt";
        bus.score = 1'b1;
        push(4, C4, 1'b1, 2'd2, 1'b0);
        push(2, G4, 1'b1, 2'd2, 1'b0);
        push(8, G4, 1'b1, 2'd3, 1'b0);
        push(8, E4, 1'b1, 2'd3, 1'b0);
        push(8, C4, 1'b1, 2'd3, 1'b0);
        push(1, SIL, 1'b0, 2'd0, 1'b1);
        push(2, SIL, 1'b0, 2'd0, 1'b0);
        run(6);
        bus.die = 1'b1;
        run(27);

        phase = "jump_die_same";
        bus.jump = 1'b1;
        bus.die  = 1'b1;
        push(8, G4, 1'b1, 2'd3, 1'b0);
        push(8, E4, 1'b1, 2'd3, 1'b0);
        push(8, C4, 1'b1, 2'd3, 1'b0);
        push(1, SIL, 1'b0, 2'd0, 1'b1);
        push(2, SIL, 1'b0, 2'd0, 1'b0);
        run(27);

        phase = "finish_and_request";
        bus.jump = 1'b1;
        push(8, G4, 1'b1, 2'd1, 1'b0);
        run(8);
        bus.score = 1'b1;
        push(1, C4, 1'b1, 2'd2, 1'b1);
        push(3, C4, 1'b1, 2'd2, 1'b0);
        push(12, G4, 1'b1, 2'd2, 1'b0);
        push(1, SIL, 1'b0, 2'd0, 1'b1);
        push(2, SIL, 1'b0, 2'd0, 1'b0);
        run(19);

        phase = "mute";
        bus.jump = 1'b1;
        push(2, G4, 1'b1, 2'd1, 1'b0);
        push(3, SIL, 1'b1, 2'd1, 1'b0);
        push(3, G4, 1'b1, 2'd1, 1'b0);
        push(1, SIL, 1'b0, 2'd0, 1'b1);
        push(2, SIL, 1'b0, 2'd0, 1'b0);
        run(2);
        bus.mute = 1'b1;
        run(3);
        bus.mute = 1'b0;
        run(6);

        phase = "reset_mid_die";
        bus.die = 1'b1;
        push(8, G4, 1'b1, 2'd3, 1'b0);
        push(3, E4, 1'b1, 2'd3, 1'b0);
        run(11);
        rst = 1'b1;
        push(1, SIL, 1'b0, 2'd0, 1'b0);
        run(1);
        rst = 1'b0;
        push(5, SIL, 1'b0, 2'd0, 1'b0);
        run(5);

        phase = "end";
        chk("scoreboard_leftover", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
